// File: rtl/reg_array_ctrl.sv
// Row register-array sequencer: reads KSIZE buffer rows per tile, drives LOAD/SHIFT/HOLD/CLEAR
// and presents one window per accepted cycle. Optional stall counter under REG_ARRAY_CTRL_PERF_EN.
module reg_array_ctrl #(
  parameter int DW     = 32,
  parameter int POY    = 16,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 12,
  parameter int TILE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic [1:0]        bank,
  output logic [1:0]        reg_array_cmd,
  output logic              o_pe_valid,
  input  logic              pe_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_stall_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_WIN  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_SHIFT = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam int K_W   = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  // Rows only matter modulo 2^(ADDR_W+2): two bits pick the bank, the rest wrap into the address.
  localparam int ROW_W = ADDR_W + 2;
  localparam logic [K_W-1:0]   K_LAST    = K_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] TILE_STEP = ROW_W'(POY * STRIDE);

  if (DW < 1 || KSIZE < 1 || POY < 1 || STRIDE < 1) begin : g_bad_cfg
    $error("reg_array_ctrl: invalid parameter set");
  end

  logic [2:0]        state, state_nxt;
  logic [TILE_W-1:0] tile, tiles_q;
  logic [K_W-1:0]    ky, sx;
  logic [ROW_W-1:0]  row_base, next_row;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [1:0]        bank_q;
  logic              sx_last, ky_last, tile_last, start_acc;

  assign sx_last   = (sx == K_LAST);
  assign ky_last   = (ky == K_LAST);
  assign tile_last = (tile == tiles_q - TILE_W'(1));
  assign start_acc = (state == S_IDLE) && start;

  always_comb begin
    state_nxt     = state;
    buf_rd_en     = 1'b0;
    reg_array_cmd = CMD_HOLD;
    next_row      = row_base + ROW_W'(ky);
    case (state)
      S_IDLE: if (start) state_nxt = (cfg_tiles != '0) ? S_CLR : S_DONE;
      S_CLR: begin
        reg_array_cmd = CMD_CLEAR;
        state_nxt     = S_RD;
      end
      S_RD: begin
        buf_rd_en = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        reg_array_cmd = CMD_LOAD;
        state_nxt     = S_WIN;
      end
      S_WIN: begin
        if (pe_ready) begin
          if (!sx_last) begin
            reg_array_cmd = CMD_SHIFT;
          end else if (!ky_last) begin
            buf_rd_en = 1'b1;
            next_row  = row_base + ROW_W'(ky) + ROW_W'(1);
            state_nxt = S_LOAD;
          end else if (!tile_last) begin
            buf_rd_en = 1'b1;
            next_row  = row_base + TILE_STEP;
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/bank follow the row being requested, then hold the last requested row.
  assign buf_rd_addr = buf_rd_en ? (base_q + next_row[ROW_W-1:2]) : addr_q;
  assign bank        = buf_rd_en ? next_row[1:0] : bank_q;
  assign o_pe_valid  = (state == S_WIN);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (start_acc) begin
      tiles_q <= cfg_tiles;
      base_q  <= cfg_base_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tile     <= '0;
      ky       <= '0;
      sx       <= '0;
      row_base <= '0;
      addr_q   <= '0;
      bank_q   <= '0;
    end else begin
      state <= state_nxt;
      if (buf_rd_en) begin
        addr_q <= buf_rd_addr;
        bank_q <= bank;
      end else if (state == S_DONE) begin
        addr_q <= '0;
        bank_q <= '0;
      end
      case (state)
        S_CLR: begin
          tile     <= '0;
          ky       <= '0;
          sx       <= '0;
          row_base <= '0;
        end
        S_LOAD: sx <= '0;
        S_WIN: begin
          if (pe_ready) begin
            if (!sx_last) begin
              sx <= sx + K_W'(1);
            end else if (!ky_last) begin
              ky <= ky + K_W'(1);
            end else if (!tile_last) begin
              tile     <= tile + TILE_W'(1);
              ky       <= '0;
              row_base <= row_base + TILE_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REG_ARRAY_CTRL_PERF_EN
  logic [31:0] stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || start_acc) stall_q <= '0;
    else if (o_pe_valid && !pe_ready) stall_q <= sat_inc(stall_q);
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_array_ctrl.sv
// Directed bench for reg_array_ctrl: per-cycle vector table for a single tile plus
// hand-written multi-tile, backpressure, zero-tile, reset, restart and wrap sequences.
module tb_reg_array_ctrl;

  localparam logic [1:0] H = 2'b00, L = 2'b01, S = 2'b10, C = 2'b11;

  typedef struct packed {
    logic        rd_en;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic [1:0]  cmd;
    logic        valid;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic st;
    logic rdy;
    obs_t exp;
  } vec_t;

  logic        clk, rst, start, pe_ready;
  logic [15:0] cfg_tiles;
  logic [11:0] cfg_base_addr;
  logic        buf_rd_en;
  logic [11:0] buf_rd_addr;
  logic [1:0]  bank, reg_array_cmd;
  logic        o_pe_valid, busy, done;
  logic [31:0] perf_stall_cnt;

  reg_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_tiles(cfg_tiles),
    .cfg_base_addr(cfg_base_addr), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .bank(bank), .reg_array_cmd(reg_array_cmd), .o_pe_valid(o_pe_valid),
    .pe_ready(pe_ready), .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_win, n_done, done_cyc, n_rd, hold_bad, n_stalled;
  logic [11:0] rd_addr[64];
  logic [1:0]  rd_bank[64];
  vec_t        vecs[17];

`ifdef REG_ARRAY_CTRL_PERF_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  function automatic obs_t mk(input logic rd, input logic [11:0] a, input logic [1:0] b,
                              input logic [1:0] cmd, input logic v, input logic bz, input logic d);
    obs_t o;
    o.rd_en = rd; o.addr = a; o.bank = b; o.cmd = cmd; o.valid = v; o.busy = bz; o.done = d;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rd_en = buf_rd_en; o.addr = buf_rd_addr; o.bank = bank; o.cmd = reg_array_cmd;
    o.valid = o_pe_valid; o.busy = busy; o.done = done;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, advance past the next rising edge.
  task automatic apply(input logic st, input logic rdy, output obs_t o);
    start = st;
    pe_ready = rdy;
    @(negedge clk);
    o = sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] tiles, input logic [11:0] base, input int stall_win,
                         input int stall_len, input int restart_cyc, input int max_cyc);
    obs_t o;
    logic rdy;
    n_win = 0; n_done = 0; done_cyc = -1; n_rd = 0; hold_bad = 0; n_stalled = 0;
    cfg_tiles = tiles;
    cfg_base_addr = base;
    for (int c = 0; c < max_cyc; c++) begin
      rdy = 1'b1;
      if (o_pe_valid && n_win == stall_win && n_stalled < stall_len) begin
        rdy = 1'b0;
        n_stalled++;
      end
      apply((c == 0) || (c == restart_cyc), rdy, o);
      if (o.rd_en && n_rd < 64) begin
        rd_addr[n_rd] = o.addr;
        rd_bank[n_rd] = o.bank;
        n_rd++;
      end
      if (o.valid && rdy) n_win++;
      if (o.valid && !rdy && o.cmd != H) hold_bad++;
      if (o.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2 && c > restart_cyc) break;
    end
    start = 1'b0;
    pe_ready = 1'b0;
    cfg_tiles = 16'hBEEF;
    cfg_base_addr = 12'hABC;
  endtask

  initial begin
    obs_t o;
    int d;
    rst = 1'b1; start = 1'b0; pe_ready = 1'b0; cfg_tiles = 16'd0; cfg_base_addr = 12'd0;

    // Single tile, base 0x10, pe_ready held high; start at cycle 0
    vecs[0]  = '{1'b1, 1'b1, mk(0, 12'h000, 0, H, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b1, mk(0, 12'h000, 0, C, 0, 1, 0)};
    vecs[2]  = '{1'b0, 1'b1, mk(1, 12'h010, 0, H, 0, 1, 0)};
    vecs[3]  = '{1'b0, 1'b1, mk(0, 12'h010, 0, L, 0, 1, 0)};
    vecs[4]  = '{1'b0, 1'b1, mk(0, 12'h010, 0, S, 1, 1, 0)};
    vecs[5]  = '{1'b0, 1'b1, mk(0, 12'h010, 0, S, 1, 1, 0)};
    vecs[6]  = '{1'b0, 1'b1, mk(1, 12'h010, 1, H, 1, 1, 0)};
    vecs[7]  = '{1'b0, 1'b1, mk(0, 12'h010, 1, L, 0, 1, 0)};
    vecs[8]  = '{1'b0, 1'b1, mk(0, 12'h010, 1, S, 1, 1, 0)};
    vecs[9]  = '{1'b0, 1'b1, mk(0, 12'h010, 1, S, 1, 1, 0)};
    vecs[10] = '{1'b0, 1'b1, mk(1, 12'h010, 2, H, 1, 1, 0)};
    vecs[11] = '{1'b0, 1'b1, mk(0, 12'h010, 2, L, 0, 1, 0)};
    vecs[12] = '{1'b0, 1'b1, mk(0, 12'h010, 2, S, 1, 1, 0)};
    vecs[13] = '{1'b0, 1'b1, mk(0, 12'h010, 2, S, 1, 1, 0)};
    vecs[14] = '{1'b0, 1'b1, mk(0, 12'h010, 2, H, 1, 1, 0)};
    vecs[15] = '{1'b0, 1'b1, mk(0, 12'h010, 2, H, 0, 1, 1)};
    vecs[16] = '{1'b0, 1'b1, mk(0, 12'h000, 0, H, 0, 0, 0)};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", 64'(sample()), 64'(mk(0, 0, 0, H, 0, 0, 0)));
    check("reset_perf", 64'(perf_stall_cnt), 64'd0);

    cfg_tiles = 16'd1;
    cfg_base_addr = 12'h010;
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].st, vecs[i].rdy, o);
      check($sformatf("single_tile_cyc%0d", i), 64'(o), 64'(vecs[i].exp));
    end

    // Three tiles: rows 0,1,2,16,17,18,32,33,34
    run_job(16'd3, 12'h010, -1, 0, -1, 100);
    for (int r = 0; r < 9; r++) begin
      check($sformatf("multi_rd%0d_addr", r), 64'(rd_addr[r]), 64'(12'h010 + 12'(4 * (r / 3))));
      check($sformatf("multi_rd%0d_bank", r), 64'(rd_bank[r]), 64'(r % 3));
    end
    check("multi_reads", 64'(n_rd), 64'd9);
    check("multi_windows", 64'(n_win), 64'd27);
    check("multi_done_count", 64'(n_done), 64'd1);
    check("multi_done_cycle", 64'(done_cyc), 64'd39);

    // Backpressure: 5 stall cycles on the 2nd window
    run_job(16'd1, 12'h010, 1, 5, -1, 100);
    check("bp_stall_applied", 64'(n_stalled), 64'd5);
    check("bp_hold_during_stall", 64'(hold_bad), 64'd0);
    check("bp_windows", 64'(n_win), 64'd9);
    check("bp_done_cycle", 64'(done_cyc), 64'd20);
    check("bp_perf_cnt", 64'(perf_stall_cnt), 64'(EXP_STALL));

    // Zero tiles
    run_job(16'd0, 12'h010, -1, 0, -1, 20);
    check("zero_reads", 64'(n_rd), 64'd0);
    check("zero_windows", 64'(n_win), 64'd0);
    check("zero_done_cycle", 64'(done_cyc), 64'd1);
    check("zero_perf_cleared", 64'(perf_stall_cnt), 64'd0);

    // Reset during the second LOAD (cycle 7)
    cfg_tiles = 16'd1;
    cfg_base_addr = 12'h010;
    for (int c = 0; c < 7; c++) apply(c == 0, 1'b1, o);
    rst = 1'b1;
    apply(1'b0, 1'b1, o);
    check("rst_in_load_cmd", 64'(o.cmd), 64'(L));
    rst = 1'b0;
    check("rst_mid_outputs", 64'(sample()), 64'(mk(0, 0, 0, H, 0, 0, 0)));
    check("rst_mid_perf", 64'(perf_stall_cnt), 64'd0);
    d = 0;
    for (int c = 0; c < 20; c++) begin
      apply(1'b0, 1'b1, o);
      if (o.done || o.busy) d++;
    end
    check("rst_no_done_or_busy", 64'(d), 64'd0);
    run_job(16'd1, 12'h010, -1, 0, -1, 60);
    check("rst_rerun_windows", 64'(n_win), 64'd9);
    check("rst_rerun_done_cycle", 64'(done_cyc), 64'd15);

    // Second start during WIN must be ignored
    run_job(16'd1, 12'h010, -1, 0, 5, 60);
    check("restart_done_count", 64'(n_done), 64'd1);
    check("restart_done_cycle", 64'(done_cyc), 64'd15);
    check("restart_windows", 64'(n_win), 64'd9);

    // Address wrap: base 0xFFF, row 16 -> 0xFFF + 4 wraps to 0x003
    run_job(16'd2, 12'hFFF, -1, 0, -1, 60);
    check("wrap_row0_addr", 64'(rd_addr[0]), 64'h0FFF);
    check("wrap_row16_addr", 64'(rd_addr[3]), 64'h003);
    check("wrap_row16_bank", 64'(rd_bank[3]), 64'd0);
    check("wrap_row18_bank", 64'(rd_bank[5]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
